// File: rtl/logic_unit_pipe_if.sv
// Command/result bus for logic_unit_pipe: input handshake, output handshake,
// result flags and the completed-transaction counter.
interface logic_unit_pipe_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic [2:0]       in_op;
  logic             in_chain;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_y;
  logic             out_zero;
  logic             out_ones;
  logic             out_parity;
  logic             cnt_clr;
  logic [CNT_W-1:0] done_cnt;

  modport master (
    output in_valid, in_a, in_b, in_op, in_chain, out_ready, cnt_clr,
    input  in_ready, out_valid, out_y, out_zero, out_ones, out_parity, done_cnt
  );

  modport slave (
    input  in_valid, in_a, in_b, in_op, in_chain, out_ready, cnt_clr,
    output in_ready, out_valid, out_y, out_zero, out_ones, out_parity, done_cnt
  );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise gate unit with valid/ready on both sides,
// result feedback (chain mode), registered flags and a saturating done counter.
module logic_unit_pipe #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  logic_unit_pipe_if.slave  bus
);

  typedef enum logic [2:0] {
    OP_AND    = 3'd0,
    OP_OR     = 3'd1,
    OP_NOT_A  = 3'd2,
    OP_NAND   = 3'd3,
    OP_NOR    = 3'd4,
    OP_XOR    = 3'd5,
    OP_XNOR   = 3'd6,
    OP_PASS_A = 3'd7
  } op_e;

  typedef struct packed {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    op_e              op;
    logic             chain;
  } s1_t;

  logic             s1_valid_q, s1_valid_d;
  s1_t              s1_q, s1_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_y_q, out_y_d;
  logic             out_zero_q, out_zero_d;
  logic             out_ones_q, out_ones_d;
  logic             out_parity_q, out_parity_d;
  logic [WIDTH-1:0] last_result_q, last_result_d;
  logic [CNT_W-1:0] done_cnt_q, done_cnt_d;

  logic             s2_adv;
  logic             in_ready_c;
  logic             in_fire;
  logic             out_fire;
  logic [WIDTH-1:0] operand_b;
  logic [WIDTH-1:0] y;

  // Stage 2 frees up whenever it is empty or being drained this cycle, so
  // in_ready depends combinationally on out_ready.
  always_comb begin
    s2_adv     = !out_valid_q || bus.out_ready;
    in_ready_c = !s1_valid_q || s2_adv;
    in_fire    = bus.in_valid && in_ready_c;
    out_fire   = out_valid_q && bus.out_ready;
  end

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d       = s1_q;
    if (in_fire) begin
      s1_valid_d = 1'b1;
      s1_d.a     = bus.in_a;
      s1_d.b     = bus.in_b;
      s1_d.op    = op_e'(bus.in_op);
      s1_d.chain = bus.in_chain;
    end else if (s2_adv) begin
      s1_valid_d = 1'b0;
    end
  end

  // last_result_q already holds the predecessor's result by the time a
  // chained op leaves stage 1, so back-to-back chaining needs no bubble.
  always_comb begin
    operand_b = s1_q.chain ? last_result_q : s1_q.b;
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    y = '0;
    case (s1_q.op)
      OP_AND:    y = s1_q.a & operand_b;
      OP_OR:     y = s1_q.a | operand_b;
      OP_NOT_A:  y = ~s1_q.a;
      OP_NAND:   y = ~(s1_q.a & operand_b);
      OP_NOR:    y = ~(s1_q.a | operand_b);
      OP_XOR:    y = s1_q.a ^ operand_b;
      OP_XNOR:   y = ~(s1_q.a ^ operand_b);
      OP_PASS_A: y = s1_q.a;
    endcase
  end

  // Result and flags only move when a real transaction enters stage 2.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_y_d       = out_y_q;
    out_zero_d    = out_zero_q;
    out_ones_d    = out_ones_q;
    out_parity_d  = out_parity_q;
    last_result_d = last_result_q;
    if (s2_adv) begin
      out_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        out_y_d       = y;
        out_zero_d    = (y == '0);
        out_ones_d    = &y;
        out_parity_d  = ^y;
        last_result_d = y;
      end
    end
  end

  always_comb begin
    done_cnt_d = done_cnt_q;
    if (bus.cnt_clr) begin
      done_cnt_d = '0;
    end else if (out_fire && (done_cnt_q != '1)) begin
      done_cnt_d = done_cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q    <= 1'b0;
      out_valid_q   <= 1'b0;
      out_y_q       <= '0;
      out_zero_q    <= 1'b0;
      out_ones_q    <= 1'b0;
      out_parity_q  <= 1'b0;
      last_result_q <= '0;
      done_cnt_q    <= '0;
    end else begin
      s1_valid_q    <= s1_valid_d;
      out_valid_q   <= out_valid_d;
      out_y_q       <= out_y_d;
      out_zero_q    <= out_zero_d;
      out_ones_q    <= out_ones_d;
      out_parity_q  <= out_parity_d;
      last_result_q <= last_result_d;
      done_cnt_q    <= done_cnt_d;
    end
  end

  // NOTE: the stage-1 payload is qualified by s1_valid_q, so it carries no reset.
  always_ff @(posedge clk) begin
    s1_q <= s1_d;
  end

  assign bus.in_ready   = in_ready_c;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_y      = out_y_q;
  assign bus.out_zero   = out_zero_q;
  assign bus.out_ones   = out_ones_q;
  assign bus.out_parity = out_parity_q;
  assign bus.done_cnt   = done_cnt_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Self-checking bench for logic_unit_pipe: directed steps plus random traffic,
// checked against an in-order transaction queue model with an occupancy count.
module tb_logic_unit_pipe;

  logic clk;
  logic rst_n;

  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(16)) ifc ();
  logic_unit_pipe_if #(.WIDTH(8), .CNT_W(2))  ifc_c ();

  logic_unit_pipe #(.WIDTH(8), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc.slave)
  );

  logic_unit_pipe #(.WIDTH(8), .CNT_W(2)) dut_c (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc_c.slave)
  );

  // The small-counter instance sees exactly the same traffic.
  assign ifc_c.in_valid  = ifc.in_valid;
  assign ifc_c.in_a      = ifc.in_a;
  assign ifc_c.in_b      = ifc.in_b;
  assign ifc_c.in_op     = ifc.in_op;
  assign ifc_c.in_chain  = ifc.in_chain;
  assign ifc_c.out_ready = ifc.out_ready;
  assign ifc_c.cnt_clr   = ifc.cnt_clr;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [7:0] q[$];      // transactions accepted and not yet delivered, issue order
  logic [7:0] got[$];    // DUT results captured at each output transfer
  bit         m_ov;
  logic [7:0] m_last;
  int         m_cnt;
  int         m_cnt_c;
  bit         last_acc;
  bit         dut_acc;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] gate(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    case (op)
      3'd0:    return a & b;
      3'd1:    return a | b;
      3'd2:    return ~a;
      3'd3:    return ~(a & b);
      3'd4:    return ~(a | b);
      3'd5:    return a ^ b;
      3'd6:    return ~(a ^ b);
      default: return a;
    endcase
  endfunction

  function automatic logic [31:0] got_at(input int i);
    if (i < got.size()) return {24'h0, got[i]};
    return 32'hFFFF_FFFF;
  endfunction

  task automatic model_reset();
    q.delete();
    m_ov    = 1'b0;
    m_last  = 8'h00;
    m_cnt   = 0;
    m_cnt_c = 0;
  endtask

  // One clock: compare at the falling edge, then advance the model across the rising edge.
  task automatic cycle();
    int         ns1;
    bit         s2_adv;
    bit         ir_e;
    bit         in_fire;
    bit         out_fire;
    logic [7:0] y;
    @(negedge clk);
    ns1    = q.size() - (m_ov ? 1 : 0);
    s2_adv = !m_ov || ifc.out_ready;
    ir_e   = (ns1 == 0) || s2_adv;
    check("in_ready", {31'h0, ifc.in_ready}, {31'h0, ir_e});
    check("out_valid", {31'h0, ifc.out_valid}, {31'h0, m_ov});
    if (m_ov && q.size() > 0) begin
      check("out_y", {24'h0, ifc.out_y}, {24'h0, q[0]});
      check("out_zero", {31'h0, ifc.out_zero}, {31'h0, (q[0] == 8'h00)});
      check("out_ones", {31'h0, ifc.out_ones}, {31'h0, (q[0] == 8'hFF)});
      check("out_parity", {31'h0, ifc.out_parity}, ($countones(q[0]) % 2));
    end
    check("done_cnt", {16'h0, ifc.done_cnt}, m_cnt);
    check("done_cnt_w2", {30'h0, ifc_c.done_cnt}, m_cnt_c);
    dut_acc  = ifc.in_valid && ifc.in_ready;
    in_fire  = ifc.in_valid && ir_e;
    out_fire = m_ov && ifc.out_ready;
    if (out_fire) got.push_back(ifc.out_y);
    @(posedge clk);
    if (ifc.cnt_clr) begin
      m_cnt   = 0;
      m_cnt_c = 0;
    end else if (out_fire) begin
      if (m_cnt < 65535) m_cnt++;
      if (m_cnt_c < 3) m_cnt_c++;
    end
    if (out_fire) void'(q.pop_front());
    if (s2_adv) m_ov = (ns1 == 1);
    if (in_fire) begin
      y = gate(ifc.in_op, ifc.in_a, ifc.in_chain ? m_last : ifc.in_b);
      m_last = y;
      q.push_back(y);
    end
    last_acc = in_fire;
    #1;
  endtask

  task automatic drive(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
    ifc.in_valid = 1'b1;
    ifc.in_op    = op;
    ifc.in_a     = a;
    ifc.in_b     = b;
    ifc.in_chain = chain;
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b, input logic chain);
    bit acc;
    acc = 1'b0;
    drive(op, a, b, chain);
    for (int n = 0; n < 50 && !acc; n++) begin
      cycle();
      acc = last_acc;
    end
    check("issue_accepted", {31'h0, acc}, 32'h1);
    ifc.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    ifc.in_valid = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    logic [7:0] exp_ops[8];
    logic [7:0] exp_flags[3];
    logic [7:0] exp_chain[3];
    logic [7:0] bp_a[3];
    logic [7:0] bp_b[3];
    logic [2:0] bp_op[3];
    int idx;
    int acc_cnt;

    exp_ops   = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33, 8'hF0};
    exp_flags = '{8'h00, 8'hFF, 8'h01};
    exp_chain = '{8'h03, 8'hFC, 8'h0C};
    bp_a      = '{8'hF0, 8'hAA, 8'hFF};
    bp_b      = '{8'h3C, 8'h0F, 8'h0F};
    bp_op     = '{3'd0, 3'd5, 3'd3};

    rst_n         = 1'b0;
    ifc.in_valid  = 1'b0;
    ifc.in_a      = '0;
    ifc.in_b      = '0;
    ifc.in_op     = '0;
    ifc.in_chain  = 1'b0;
    ifc.out_ready = 1'b1;
    ifc.cnt_clr   = 1'b0;
    model_reset();

    // Reset state
    @(posedge clk);
    #1;
    check("rst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("rst_out_y", {24'h0, ifc.out_y}, 32'h0);
    check("rst_out_zero", {31'h0, ifc.out_zero}, 32'h0);
    check("rst_out_ones", {31'h0, ifc.out_ones}, 32'h0);
    check("rst_out_parity", {31'h0, ifc.out_parity}, 32'h0);
    check("rst_done_cnt", {16'h0, ifc.done_cnt}, 32'h0);
    check("rst_in_ready", {31'h0, ifc.in_ready}, 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Chained op straight after reset uses b = 0
    got.delete();
    issue(3'd1, 8'h11, 8'hAA, 1'b1);
    drain(3);
    check("chain_after_reset", got_at(0), 32'h11);

    // All eight opcodes back to back
    got.delete();
    for (int i = 0; i < 8; i++) issue(3'(i), 8'hF0, 8'h3C, 1'b0);
    drain(3);
    check("ops_count", got.size(), 8);
    for (int i = 0; i < 8; i++) check($sformatf("op%0d_y", i), got_at(i), {24'h0, exp_ops[i]});

    // Flag corner values
    got.delete();
    issue(3'd0, 8'h0F, 8'hF0, 1'b0);
    issue(3'd6, 8'h55, 8'h55, 1'b0);
    issue(3'd7, 8'h01, 8'h00, 1'b0);
    drain(3);
    for (int i = 0; i < 3; i++) check($sformatf("flags%0d_y", i), got_at(i), {24'h0, exp_flags[i]});

    // Back-to-back chaining
    got.delete();
    issue(3'd1, 8'h01, 8'h02, 1'b0);
    issue(3'd5, 8'hFF, 8'h77, 1'b1);
    issue(3'd0, 8'h0F, 8'h99, 1'b1);
    drain(3);
    for (int i = 0; i < 3; i++) check($sformatf("chain%0d_y", i), got_at(i), {24'h0, exp_chain[i]});

    // Backpressure: five stalled cycles while offering three transactions
    ifc.cnt_clr = 1'b1;
    drain(1);
    ifc.cnt_clr = 1'b0;
    got.delete();
    ifc.out_ready = 1'b0;
    idx = 0;
    acc_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      drive(bp_op[idx], bp_a[idx], bp_b[idx], 1'b0);
      cycle();
      if (dut_acc) acc_cnt++;
      if (last_acc && idx < 2) idx++;
    end
    check("bp_accepts", acc_cnt, 2);
    check("bp_hold_y", {24'h0, ifc.out_y}, 32'h30);
    check("bp_nothing_out", got.size(), 0);
    ifc.out_ready = 1'b1;
    issue(bp_op[2], bp_a[2], bp_b[2], 1'b0);
    drain(4);
    check("bp_count", got.size(), 3);
    check("bp_y0", got_at(0), 32'h30);
    check("bp_y1", got_at(1), 32'hA5);
    check("bp_y2", got_at(2), 32'hF0);
    check("bp_done_cnt", {16'h0, ifc.done_cnt}, 32'd3);

    // Counter saturation and clear priority
    ifc.cnt_clr = 1'b1;
    drain(1);
    ifc.cnt_clr = 1'b0;
    for (int i = 0; i < 5; i++) issue(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom), 1'b0);
    drain(3);
    check("sat_done_cnt_w2", {30'h0, ifc_c.done_cnt}, 32'd3);
    check("sat_done_cnt_w16", {16'h0, ifc.done_cnt}, 32'd5);
    issue(3'd1, 8'h12, 8'h34, 1'b0);
    cycle();
    ifc.cnt_clr = 1'b1;
    cycle();
    ifc.cnt_clr = 1'b0;
    check("clr_prio_w16", {16'h0, ifc.done_cnt}, 32'd0);
    check("clr_prio_w2", {30'h0, ifc_c.done_cnt}, 32'd0);
    drain(2);

    // Asynchronous reset with both stages full
    ifc.out_ready = 1'b0;
    issue(3'd1, 8'h0F, 8'hF0, 1'b0);
    issue(3'd5, 8'hAA, 8'h55, 1'b0);
    got.delete();
    #1 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", {31'h0, ifc.out_valid}, 32'h0);
    check("midrst_done_cnt", {16'h0, ifc.done_cnt}, 32'h0);
    check("midrst_in_ready", {31'h0, ifc.in_ready}, 32'h1);
    #1 rst_n = 1'b1;
    model_reset();
    ifc.out_ready = 1'b1;
    drain(4);
    check("midrst_no_stale", got.size(), 0);
    issue(3'd5, 8'h3C, 8'hC3, 1'b1);
    drain(3);
    check("midrst_chain_b0", got_at(0), 32'h3C);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      ifc.in_valid  = ($urandom_range(0, 3) != 0);
      ifc.in_a      = 8'($urandom);
      ifc.in_b      = 8'($urandom);
      ifc.in_op     = 3'($urandom_range(0, 7));
      ifc.in_chain  = ($urandom_range(0, 2) == 0);
      ifc.out_ready = ($urandom_range(0, 3) != 0);
      ifc.cnt_clr   = ($urandom_range(0, 49) == 0);
      cycle();
    end
    ifc.out_ready = 1'b1;
    ifc.cnt_clr   = 1'b0;
    drain(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
